// File: rtl/parser_cfg_table.sv
// Parser action table with its own control-stream loader.
// Control packets addressed to MOD_ID write or read back entries; a registered lookup port indexes the table by a key slice.
module parser_cfg_table #(
   parameter int              C_S_AXIS_DATA_WIDTH  = 512,
   parameter int              C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [2:0]      MOD_ID               = 3'b000,
   parameter logic [15:0]     CTRL_FLAG            = 16'hF2F1,
   parameter int              ENTRY_WIDTH          = 160,
   parameter int              TBL_DEPTH_BITS       = 5,
   parameter int              C_VLANID_WIDTH       = 12,
   parameter int              KEY_IDX_LSB          = 4
) (
   input  logic                              axis_clk,
   input  logic                              aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
   input  logic                              ctrl_s_axis_tvalid,
   input  logic                              ctrl_s_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_m_axis_tkeep,
   output logic                              ctrl_m_axis_tvalid,
   output logic                              ctrl_m_axis_tlast,
   input  logic [C_VLANID_WIDTH-1:0]         lkp_key,
   input  logic                              lkp_valid,
   output logic [ENTRY_WIDTH-1:0]            lkp_entry,
   output logic                              lkp_entry_valid,
   output logic                              cfg_err,
   output logic [15:0]                       cfg_wr_cnt
);

   localparam int DW    = C_S_AXIS_DATA_WIDTH;
   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << TBL_DEPTH_BITS;
   localparam logic [TBL_DEPTH_BITS-1:0] IDX_ONE = 1;

   typedef enum logic [2:0] {IDLE, FWD, WR, RD, DROP} state_t;

   state_t                         r_state;
   logic [TBL_DEPTH_BITS-1:0]      r_idx;
   logic [ENTRY_WIDTH-1:0]         r_tbl [DEPTH];
   logic [DW-1:0]                  r_m_tdata;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] r_m_tuser;
   logic [NB-1:0]                  r_m_tkeep;
   logic                           r_m_tvalid;
   logic                           r_m_tlast;
   logic                           r_cfg_err;
   logic [15:0]                    r_wr_cnt;
   logic [ENTRY_WIDTH-1:0]         r_lkp_entry;
   logic                           r_lkp_vld;

   logic [DW-1:0]                  w_rev_in;
   logic [DW-1:0]                  w_rd_rev;
   logic [DW-1:0]                  w_rd_data;
   logic [ENTRY_WIDTH-1:0]         w_entry;
   logic [2:0]                     w_mod_id;
   logic [15:0]                    w_flag;
   logic [TBL_DEPTH_BITS-1:0]      w_start;
   logic [7:0]                     w_opcode;
   logic                           w_match;
   logic                           w_wr;
   logic [TBL_DEPTH_BITS-1:0]      w_lkp_idx;
   logic                           w_unused_key;

   // Entries live in byte-reversed order: input byte 0 lands in the entry's MSB byte.
   for (genvar g = 0; g < NB; g++) begin : g_rev
      assign w_rev_in[DW-1-8*g -: 8]  = ctrl_s_axis_tdata[8*g +: 8];
      assign w_rd_data[8*g +: 8]      = w_rd_rev[DW-1-8*g -: 8];
   end

   assign w_entry   = w_rev_in[DW-1 -: ENTRY_WIDTH];
   assign w_mod_id  = ctrl_s_axis_tdata[368 +: 3];
   assign w_flag    = ctrl_s_axis_tdata[335:320];
   assign w_start   = ctrl_s_axis_tdata[384 +: TBL_DEPTH_BITS];
   assign w_opcode  = ctrl_s_axis_tdata[392 +: 8];
   assign w_match   = ctrl_s_axis_tvalid && (w_mod_id == MOD_ID) && (w_flag == CTRL_FLAG);
   assign w_wr      = ctrl_s_axis_tvalid && (r_state == WR);
   assign w_lkp_idx = lkp_key[KEY_IDX_LSB +: TBL_DEPTH_BITS];
   assign w_unused_key = ^lkp_key;

   always_comb begin
      w_rd_rev = w_rev_in;
      w_rd_rev[DW-1 -: ENTRY_WIDTH] = r_tbl[r_idx];
   end

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_m_tdata  <= '0;
         r_m_tuser  <= '0;
         r_m_tkeep  <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_wr_cnt   <= '0;
      end else begin
         r_m_tvalid <= 1'b0;
         r_cfg_err  <= 1'b0;
         if (ctrl_s_axis_tvalid) begin
            r_m_tdata <= ctrl_s_axis_tdata;
            r_m_tuser <= ctrl_s_axis_tuser;
            r_m_tkeep <= ctrl_s_axis_tkeep;
            r_m_tlast <= ctrl_s_axis_tlast;
            case (r_state)
               IDLE: begin
                  if (!w_match) begin
                     r_m_tvalid <= 1'b1;
                     if (!ctrl_s_axis_tlast) r_state <= FWD;
                  end else begin
                     r_idx <= w_start;
                     case (w_opcode)
                        8'h00: if (!ctrl_s_axis_tlast) r_state <= WR;
                        8'h01: begin
                           r_m_tvalid <= 1'b1;
                           if (!ctrl_s_axis_tlast) r_state <= RD;
                        end
                        default: begin
                           r_cfg_err <= 1'b1;
                           if (!ctrl_s_axis_tlast) r_state <= DROP;
                        end
                     endcase
                  end
               end
               FWD: begin
                  r_m_tvalid <= 1'b1;
                  if (ctrl_s_axis_tlast) r_state <= IDLE;
               end
               WR: begin
                  r_idx <= r_idx + IDX_ONE;
                  if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
                  if (ctrl_s_axis_tlast) r_state <= IDLE;
               end
               RD: begin
                  r_m_tdata  <= w_rd_data;
                  r_m_tvalid <= 1'b1;
                  r_idx      <= r_idx + IDX_ONE;
                  if (ctrl_s_axis_tlast) r_state <= IDLE;
               end
               DROP: if (ctrl_s_axis_tlast) r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < DEPTH; i++) r_tbl[i] <= '0;
      end else if (w_wr) begin
         r_tbl[r_idx] <= w_entry;
      end
   end

   // Write-first: a lookup colliding with this cycle's write sees the new entry.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         r_lkp_entry <= '0;
         r_lkp_vld   <= 1'b0;
      end else begin
         r_lkp_vld <= lkp_valid;
         if (lkp_valid)
            r_lkp_entry <= (w_wr && (r_idx == w_lkp_idx)) ? w_entry : r_tbl[w_lkp_idx];
      end
   end

   assign ctrl_m_axis_tdata  = r_m_tdata;
   assign ctrl_m_axis_tuser  = r_m_tuser;
   assign ctrl_m_axis_tkeep  = r_m_tkeep;
   assign ctrl_m_axis_tvalid = r_m_tvalid;
   assign ctrl_m_axis_tlast  = r_m_tlast;
   assign cfg_err            = r_cfg_err;
   assign cfg_wr_cnt         = r_wr_cnt;
   assign lkp_entry          = r_lkp_entry;
   assign lkp_entry_valid    = r_lkp_vld;

endmodule

// File: tb/tb_parser_cfg_table.sv
// Directed bench for parser_cfg_table: expected control-output beats are queued at drive time and
// checked by a monitor; table state is tracked through the lookup port.
module tb_parser_cfg_table;
   localparam int DW = 512, UW = 128, KW = 64, EW = 160;

   logic            axis_clk = 1'b0;
   logic            aresetn;
   logic [DW-1:0]   s_tdata;
   logic [UW-1:0]   s_tuser;
   logic [KW-1:0]   s_tkeep;
   logic            s_tvalid, s_tlast;
   logic [DW-1:0]   m_tdata;
   logic [UW-1:0]   m_tuser;
   logic [KW-1:0]   m_tkeep;
   logic            m_tvalid, m_tlast;
   logic [11:0]     lkp_key;
   logic            lkp_valid;
   logic [EW-1:0]   lkp_entry;
   logic            lkp_entry_valid;
   logic            cfg_err;
   logic [15:0]     cfg_wr_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [DW-1:0] d;
      logic [UW-1:0] u;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;
   beat_t q[$];

   always #5 axis_clk = ~axis_clk;

   parser_cfg_table dut (
      .axis_clk(axis_clk), .aresetn(aresetn),
      .ctrl_s_axis_tdata(s_tdata), .ctrl_s_axis_tuser(s_tuser), .ctrl_s_axis_tkeep(s_tkeep),
      .ctrl_s_axis_tvalid(s_tvalid), .ctrl_s_axis_tlast(s_tlast),
      .ctrl_m_axis_tdata(m_tdata), .ctrl_m_axis_tuser(m_tuser), .ctrl_m_axis_tkeep(m_tkeep),
      .ctrl_m_axis_tvalid(m_tvalid), .ctrl_m_axis_tlast(m_tlast),
      .lkp_key(lkp_key), .lkp_valid(lkp_valid), .lkp_entry(lkp_entry),
      .lkp_entry_valid(lkp_entry_valid), .cfg_err(cfg_err), .cfg_wr_cnt(cfg_wr_cnt)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd512();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [DW-1:0] hdr(input logic [7:0] mod, input logic [15:0] flg,
                                         input logic [7:0] st, input logic [7:0] op);
      logic [DW-1:0] d;
      d = '0;
      d[63:0]     = {$urandom, $urandom};
      d[368 +: 8] = mod;
      d[335:320]  = flg;
      d[384 +: 8] = st;
      d[392 +: 8] = op;
      return d;
   endfunction

   // Entry byte i (counted from its MSB end) sits at beat byte i.
   function automatic logic [DW-1:0] put_entry(input logic [DW-1:0] d, input logic [EW-1:0] e);
      logic [DW-1:0] r;
      r = d;
      for (int i = 0; i < EW/8; i++) r[8*i +: 8] = e[EW-1-8*i -: 8];
      return r;
   endfunction

   function automatic logic [EW-1:0] rnd_entry();
      logic [DW-1:0] d;
      d = rnd512();
      return d[EW-1:0];
   endfunction

   task automatic drive(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic [KW-1:0] k, input logic l);
      @(posedge axis_clk); #1;
      s_tdata = d; s_tuser = u; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
   endtask

   task automatic idle();
      @(posedge axis_clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0; lkp_valid = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic [KW-1:0] k, input logic l);
      beat_t b;
      b.d = d; b.u = u; b.k = k; b.l = l;
      q.push_back(b);
   endtask

   task automatic lookup_chk(input string tag, input logic [11:0] key, input logic [EW-1:0] exp);
      @(posedge axis_clk); #1;
      s_tvalid = 1'b0; lkp_key = key; lkp_valid = 1'b1;
      @(posedge axis_clk); #1;
      lkp_valid = 1'b0;
      check({tag, "_vld"}, DW'(lkp_entry_valid), DW'(1'b1));
      check(tag, DW'(lkp_entry), DW'(exp));
   endtask

   always @(negedge axis_clk) begin
      if (m_tvalid) begin
         if (q.size() == 0) begin
            check("unexpected_beat", DW'(m_tvalid), DW'(1'b0));
         end else begin
            beat_t b;
            b = q.pop_front();
            check("out_tdata", m_tdata, b.d);
            check("out_tuser", DW'(m_tuser), DW'(b.u));
            check("out_tkeep", DW'(m_tkeep), DW'(b.k));
            check("out_tlast", DW'(m_tlast), DW'(b.l));
         end
      end
   end

   initial begin
      logic [EW-1:0] A, B, C, X, Y, N;
      logic [DW-1:0] d0, d1, d2;
      logic [UW-1:0] u;
      logic [KW-1:0] k;
      A = rnd_entry(); B = rnd_entry(); C = rnd_entry();
      X = rnd_entry(); Y = rnd_entry(); N = rnd_entry();
      u = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom};

      aresetn = 1'b0; s_tdata = '0; s_tuser = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      lkp_key = '0; lkp_valid = 1'b0;
      #22 aresetn = 1'b1;
      check("rst_tvalid", DW'(m_tvalid), '0);
      check("rst_cfg_err", DW'(cfg_err), '0);
      check("rst_wr_cnt", DW'(cfg_wr_cnt), '0);
      check("rst_lkp_vld", DW'(lkp_entry_valid), '0);
      check("rst_lkp_entry", DW'(lkp_entry), '0);
      lookup_chk("lkp_after_rst", 12'h0A0, '0);

      // Burst write of A,B,C starting at 3; every beat consumed.
      drive(hdr(8'h00, 16'hF2F1, 8'd3, 8'h00), u, k, 1'b0);
      drive(put_entry(rnd512(), A), u, k, 1'b0);
      drive(put_entry(rnd512(), B), u, k, 1'b0);
      drive(put_entry(rnd512(), C), u, k, 1'b1);
      idle();
      check("wr_cnt_3", DW'(cfg_wr_cnt), DW'(16'd3));
      lookup_chk("lkp_idx4_B", 12'h040, B);
      lookup_chk("lkp_idx3_A", 12'h030, A);
      lookup_chk("lkp_idx5_C", 12'h050, C);

      // Start index 0x3F truncates to 31 and the burst wraps to 0.
      drive(hdr(8'h00, 16'hF2F1, 8'h3F, 8'h00), u, k, 1'b0);
      drive(put_entry(rnd512(), X), u, k, 1'b0);
      drive(put_entry(rnd512(), Y), u, k, 1'b1);
      idle();
      check("wr_cnt_5", DW'(cfg_wr_cnt), DW'(16'd5));
      lookup_chk("lkp_idx31_X", 12'h1F0, X);
      lookup_chk("lkp_idx0_Y", 12'h000, Y);

      // Foreign packet; its middle beat looks like a write header.
      d0 = hdr(8'h00, 16'h1234, 8'd3, 8'h00);
      d1 = hdr(8'h00, 16'hF2F1, 8'd3, 8'h00);
      d2 = rnd512();
      push(d0, u, k, 1'b0); drive(d0, u, k, 1'b0);
      push(d1, u, ~k, 1'b0); drive(d1, u, ~k, 1'b0);
      push(d2, ~u, k, 1'b1); drive(d2, ~u, k, 1'b1);
      idle(); idle();
      lookup_chk("fwd_tbl_untouched", 12'h030, A);
      check("fwd_wr_cnt", DW'(cfg_wr_cnt), DW'(16'd5));

      // Read-back from 3: header forwarded, payloads carry A then B.
      d0 = hdr(8'h00, 16'hF2F1, 8'd3, 8'h01);
      d1 = rnd512();
      d2 = rnd512();
      push(d0, u, k, 1'b0); drive(d0, u, k, 1'b0);
      push(put_entry(d1, A), u, k, 1'b0); drive(d1, u, k, 1'b0);
      push(put_entry(d2, B), u, k, 1'b1); drive(d2, u, k, 1'b1);
      idle(); idle();

      // Unknown opcode: error pulse, whole packet dropped.
      drive(hdr(8'h00, 16'hF2F1, 8'd0, 8'h07), u, k, 1'b0);
      drive(rnd512(), u, k, 1'b1);
      check("cfg_err_pulse", DW'(cfg_err), DW'(1'b1));
      idle();
      check("cfg_err_clear", DW'(cfg_err), '0);

      // Write to index 6 with a colliding lookup in the same cycle.
      drive(hdr(8'h00, 16'hF2F1, 8'd6, 8'h00), u, k, 1'b0);
      drive(put_entry(rnd512(), N), u, k, 1'b1);
      lkp_key = 12'h060; lkp_valid = 1'b1;
      idle();
      check("bypass_vld", DW'(lkp_entry_valid), DW'(1'b1));
      check("bypass_entry", DW'(lkp_entry), DW'(N));
      check("wr_cnt_6", DW'(cfg_wr_cnt), DW'(16'd6));

      // Reset in the middle of a write burst.
      drive(hdr(8'h00, 16'hF2F1, 8'd0, 8'h00), u, k, 1'b0);
      drive(put_entry(rnd512(), N), u, k, 1'b0);
      idle();
      aresetn = 1'b0;
      #7 aresetn = 1'b1;
      check("rst2_wr_cnt", DW'(cfg_wr_cnt), '0);
      lookup_chk("rst2_idx3", 12'h030, '0);
      lookup_chk("rst2_idx0", 12'h000, '0);
      d0 = rnd512();
      d0[335:320] = 16'h0000;
      push(d0, u, k, 1'b1); drive(d0, u, k, 1'b1);
      idle(); idle(); idle();
      check("queue_empty", DW'(q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed no end expected end by 50000");
      $fatal(1, "timeout");
   end
endmodule
